// File: rtl/div32_seq_pkg.sv
// Shared ALU package for the iterative divider.
// Holds the divider FSM state encoding, the iteration count, the result
// constants for the two special cases, and a two's-complement negate helper.
package div32_seq_pkg;

   localparam int          DIV_ITER   = 32;
   localparam int          CNT_W      = $clog2(DIV_ITER);
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } div_state_e;

   // Two's-complement negate. Used for the magnitude and sign fix-ups, which
   // are plain inline logic rather than extra adder instances.
   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

endpackage

// File: rtl/div32_seq_adder32b.sv
// Adder32b: 32-bit combinational add/subtract unit.
// Ports:
//   A, B  in  32  operands
//   SUB   in  1   1 = A - B (A + ~B + 1), 0 = A + B
//   SUM   out 32  result
//   COUT  out 1   carry-out; when SUB = 1, COUT = 1 means no borrow (A >= B)
module Adder32b (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        SUB,
   output logic [31:0] SUM,
   output logic        COUT
);

   logic [32:0] full;

   always_comb begin
      full = {1'b0, A} + {1'b0, B ^ {32{SUB}}} + {32'd0, SUB};
   end

   assign SUM  = full[31:0];
   assign COUT = full[32];

endmodule

// File: rtl/div32_seq.sv
// div32_seq: iterative restoring 32-bit divider, one quotient bit per cycle.
// Implements RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero
// and signed overflow.
// Ports:
//   CLK     in  1   clock, rising edge
//   RST     in  1   synchronous active-high reset
//   START   in  1   request, accepted only in IDLE or DONE
//   SIGNED  in  1   1 = DIV/REM, 0 = DIVU/REMU (sampled with START)
//   A, B    in  32  dividend / divisor (sampled with START)
//   BUSY    out 1   high in PREP, ITER and FIX
//   DONE    out 1   one-cycle pulse, Q/R valid
//   Q, R    out 32  quotient / remainder, held until the next result
module div32_seq
   import div32_seq_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic        SIGNED,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] Q,
   output logic [31:0] R
);

   div_state_e       state_q, state_d;
   logic [31:0]      a_q, a_d;        // raw operands captured with START
   logic [31:0]      b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [31:0]      bmag_q, bmag_d;  // |B| used by every trial subtraction
   logic [31:0]      rem_q, rem_d;
   logic [31:0]      dvd_q, dvd_d;    // dividend shifts out, quotient shifts in
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sq_q, sq_d;
   logic             sr_q, sr_d;
   logic [31:0]      q_q, q_d;
   logic [31:0]      r_q, r_d;

   logic [31:0]      rs;
   logic             t;
   logic [31:0]      sum;
   logic             cout;
   logic             qb;
   logic [31:0]      amag;

   // Shifted partial remainder; t is the bit pushed out of the 32-bit
   // register. When t is set the true remainder is >= 2^32 > |B|, so the
   // subtraction always succeeds and the truncated adder sum is still exact.
   assign rs = {rem_q[30:0], dvd_q[31]};
   assign t  = rem_q[31];
   assign qb = t | cout;

   Adder32b u_add (
      .A    (rs),
      .B    (bmag_q),
      .SUB  (1'b1),
      .SUM  (sum),
      .COUT (cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      bmag_d  = bmag_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      q_d     = q_q;
      r_d     = r_q;
      amag    = (sgn_q & a_q[31]) ? neg32(a_q) : a_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (START) begin
               a_d     = A;
               b_d     = B;
               sgn_d   = SIGNED;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            sq_d   = sgn_q & (a_q[31] ^ b_q[31]);
            sr_d   = sgn_q & a_q[31];
            bmag_d = (sgn_q & b_q[31]) ? neg32(b_q) : b_q;
            rem_d  = '0;
            dvd_d  = amag;
            cnt_d  = '0;
            if (b_q == '0) begin
               q_d     = DIV_ZERO_Q;
               r_d     = a_q;
               state_d = ST_DONE;
            end else if (sgn_q && (a_q == INT_MIN) && (b_q == 32'hFFFF_FFFF)) begin
               q_d     = INT_MIN;
               r_d     = '0;
               state_d = ST_DONE;
            end else begin
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            rem_d = qb ? sum : rs;
            dvd_d = {dvd_q[30:0], qb};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_ITER - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            q_d     = sq_q ? neg32(dvd_q) : dvd_q;
            r_d     = sr_q ? neg32(rem_q) : rem_q;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         bmag_q  <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         cnt_q   <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         bmag_q  <= bmag_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         q_q     <= q_d;
         r_q     <= r_d;
      end
   end

   assign BUSY = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
   assign DONE = (state_q == ST_DONE);
   assign Q    = q_q;
   assign R    = r_q;

endmodule

// File: tb/tb_div32_seq.sv
module tb_div32_seq;

   logic        CLK = 1'b0;
   logic        RST, START, SIGNED;
   logic [31:0] A, B;
   logic        BUSY, DONE;
   logic [31:0] Q, R;

   int          n_run = 0;
   int          n_fail = 0;
   logic [31:0] prev_q = '0;
   logic [31:0] prev_r = '0;

   div32_seq dut (
      .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED),
      .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called with time just after a rising edge; drives START in "cycle 0".
   // poke > 0 : pulse START with other operands in that cycle (must be ignored)
   // rstc > 0 : assert RST in that cycle; then expect reset values and no DONE
   task automatic run_op(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input int elat, input int poke, input int rstc);
      int  n;
      int  busy_n;
      int  done_at;
      SIGNED = sgn; A = a; B = b; START = 1'b1;
      n = 0; busy_n = 0; done_at = 0;
      while (done_at == 0 && n < 60) begin
         @(posedge CLK); #1;
         n++;
         START = 1'b0; RST = 1'b0; A = '0; B = '0; SIGNED = 1'b0;
         if (BUSY) busy_n++;
         if (n == 1) begin
            chk({tag, " busy c1"}, 32'(BUSY), 32'd1);
            chk({tag, " q held"}, Q, prev_q);
            chk({tag, " r held"}, R, prev_r);
         end
         if (rstc > 0 && n == rstc + 1) begin
            chk({tag, " rst busy"}, 32'(BUSY), 32'd0);
            chk({tag, " rst q"}, Q, 32'd0);
            chk({tag, " rst r"}, R, 32'd0);
            prev_q = '0; prev_r = '0;
         end
         if (DONE) done_at = n;
         if (n == poke) begin
            START = 1'b1; A = 32'd5; B = 32'd1; SIGNED = 1'b1;
         end
         if (n == rstc) RST = 1'b1;
         if (rstc > 0 && n >= 40) break;
      end
      if (rstc > 0) begin
         chk({tag, " no done"}, 32'(done_at), 32'd0);
      end else begin
         chk({tag, " latency"}, 32'(done_at), 32'(elat));
         chk({tag, " q"}, Q, eq);
         chk({tag, " r"}, R, er);
         chk({tag, " busy at done"}, 32'(BUSY), 32'd0);
         chk({tag, " busy cycles"}, 32'(busy_n), 32'(elat - 1));
         prev_q = eq; prev_r = er;
      end
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("reset busy", 32'(BUSY), 32'd0);
      chk("reset done", 32'(DONE), 32'd0);
      chk("reset q", Q, 32'd0);
      chk("reset r", R, 32'd0);

      run_op("u100/7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         35, 0, 0);
      run_op("s-7/2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 35, 0, 0);
      run_op("s7/-2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         35, 0, 0);
      run_op("u/0",       1'b0, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      2,  0, 0);
      run_op("s/0",       1'b1, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      2,  0, 0);
      run_op("s-7/0",     1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 2,  0, 0);
      run_op("s ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         2,  0, 0);
      run_op("u ovfpat",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 35, 0, 0);
      run_op("u t-path",  1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 35, 0, 0);
      run_op("s min/2",   1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         35, 0, 0);
      run_op("s-100/7",   1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 35, 0, 0);
      run_op("u0/5",      1'b0, 32'd0,         32'd5,         32'd0,         32'd0,         35, 0, 0);
      run_op("busy start",1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         35, 10, 0);
      run_op("mid rst",   1'b0, 32'd100,       32'd7,         32'd0,         32'd0,         35, 0, 12);
      run_op("after rst", 1'b0, 32'd1000,      32'd10,        32'd100,       32'd0,         35, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
